// File: rtl/servo_pkg.sv
// Shared types and constants for the servo motion blocks.
package servo_pkg;

  localparam int unsigned POS_W          = 8;
  localparam int unsigned SPEED_W        = 4;
  localparam int unsigned HOME_POS_DEF   = 128;
  localparam int unsigned UPDATE_DIV_DEF = 1000000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Unsigned distance between two positions, one bit wider so it never wraps
  function automatic logic [POS_W:0] abs_diff(input logic [POS_W-1:0] a,
                                               input logic [POS_W-1:0] b);
    if (a >= b) return {1'b0, a} - {1'b0, b};
    else        return {1'b0, b} - {1'b0, a};
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running frame counter; tick pulses for one cycle while count == DIV-1.
module tick_divider #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(DIV);

  logic [CNT_W-1:0] count;

  // tick is registered one count early so it lines up with count == DIV-1
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      if (count == CNT_W'(DIV - 1)) count <= '0;
      else                          count <= count + CNT_W'(1);
      tick <= (count == CNT_W'(DIV - 2));
    end
  end

endmodule

// File: rtl/servo_ramp.sv
// Motion sequencer: slews position toward a commanded target one bounded
// step per frame tick, holds for a settle period, then pulses done.
module servo_ramp
  import servo_pkg::*;
#(
  parameter int unsigned UPDATE_DIV = UPDATE_DIV_DEF,
  parameter int unsigned HOLD_TICKS = 10,
  parameter int unsigned HOME_POS   = HOME_POS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [POS_W-1:0]   cmd_pos,
  input  logic [SPEED_W-1:0] cmd_speed,
  output logic [POS_W-1:0]   position,
  output logic               busy,
  output logic               done
);

  localparam int unsigned EXT_W     = POS_W + 1;
  localparam int unsigned HOLD_W    = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam bit          HOLD_ZERO = (HOLD_TICKS == 0);

  state_t             state;
  logic [POS_W-1:0]   tgt;
  logic [SPEED_W-1:0] stp;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [POS_W:0]     diff;
  logic               tick;

  tick_divider #(.DIV(UPDATE_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign diff = abs_diff(tgt, position);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      position  <= POS_W'(HOME_POS);
      tgt       <= '0;
      stp       <= '0;
      hold_cnt  <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            tgt       <= cmd_pos;
            stp       <= cmd_speed;
            hold_cnt  <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            // speed 0 jumps straight to target; an equal target has nothing to move
            if (cmd_speed == '0 || cmd_pos == position) begin
              if (cmd_speed == '0) position <= cmd_pos;
              state <= HOLD;
              done  <= HOLD_ZERO;
            end else begin
              state <= MOVE;
            end
          end
        end

        MOVE: begin
          if (tick) begin
            if (diff <= EXT_W'(stp)) begin
              position <= tgt;
              hold_cnt <= '0;
              state    <= HOLD;
              done     <= HOLD_ZERO;
            end else if (tgt > position) begin
              position <= position + POS_W'(stp);
            end else begin
              position <= position - POS_W'(stp);
            end
          end
        end

        HOLD: begin
          // done cycle is the last cycle in HOLD, so no accept can overlap it
          if (done) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end else if (tick) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
            if ((hold_cnt + HOLD_W'(1)) == HOLD_W'(HOLD_TICKS)) done <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_servo_ramp.sv
// Bench for servo_ramp: trajectory-level reference model checked every cycle,
// plus directed scenarios with hand-computed positions.
module tb_servo_ramp;

  localparam int unsigned DIV = 4;
  localparam int unsigned HT  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_pos = 8'd0;
  logic [3:0] cmd_speed = 4'd0;
  logic       cmd_ready;
  logic [7:0] position;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  servo_ramp #(.UPDATE_DIV(DIV), .HOLD_TICKS(HT), .HOME_POS(128)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_pos   (cmd_pos),
    .cmd_speed (cmd_speed),
    .position  (position),
    .busy      (busy),
    .done      (done)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 moving, 2 holding. On accept the whole
  // list of per-tick positions is precomputed; each tick consumes one entry.
  int  m_pos, m_phase, m_hold, m_k;
  bit  m_done;
  bit  m_valid = 1'b0;
  int  m_q[$];

  always @(posedge clk) begin
    if (rst) begin
      m_pos = 128; m_phase = 0; m_hold = 0; m_k = 0; m_done = 1'b0;
      m_q.delete();
      m_valid = 1'b1;
    end else if (m_valid) begin
      bit tick_now;
      tick_now = ((m_k % DIV) == DIV - 1);
      m_k++;
      if (m_phase == 0) begin
        if (cmd_valid) begin
          int t, s, p, d;
          t = int'(cmd_pos); s = int'(cmd_speed); p = m_pos;
          if (s == 0 || t == p) begin
            m_pos = t; m_phase = 2; m_hold = 0; m_done = (HT == 0);
          end else begin
            while (p != t) begin
              d = t - p;
              if ((d < 0 ? -d : d) <= s) p = t;
              else                       p = p + ((d > 0) ? s : -s);
              m_q.push_back(p);
            end
            m_phase = 1;
          end
        end
      end else if (m_phase == 1) begin
        if (tick_now) begin
          m_pos = m_q.pop_front();
          if (m_q.size() == 0) begin
            m_phase = 2; m_hold = 0; m_done = (HT == 0);
          end
        end
      end else begin
        if (m_done) begin
          m_done = 1'b0; m_phase = 0;
        end else if (tick_now) begin
          m_hold++;
          if (m_hold == HT) m_done = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus a log of position changes
  int prev_pos = 128;
  int seen[$];
  int done_cnt = 0;

  always @(negedge clk) begin
    if (m_valid) begin
      check("position",  int'(position),  m_pos);
      check("cmd_ready", int'(cmd_ready), int'(m_phase == 0));
      check("busy",      int'(busy),      int'(m_phase != 0));
      check("done",      int'(done),      int'(m_done));
    end
    if (!rst && int'(position) != prev_pos) seen.push_back(int'(position));
    prev_pos = int'(position);
    if (done) done_cnt++;
  end

  task automatic send(input int p, input int s);
    seen.delete();
    check("ready_before_send", int'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_pos   = 8'(p);
    cmd_speed = 4'(s);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int c;
    c = 0;
    while (!done && c < 200) begin
      @(negedge clk);
      c++;
    end
    check({name, "_no_timeout"}, int'(c < 200), 1);
    check({name, "_ready_in_done"}, int'(cmd_ready), 0);
    @(negedge clk);
    check({name, "_ready_after"}, int'(cmd_ready), 1);
    check({name, "_done_cleared"}, int'(done), 0);
  endtask

  task automatic check_seen(input string name, input int exp[$]);
    check({name, "_steps"}, seen.size(), exp.size());
    for (int i = 0; i < exp.size() && i < seen.size(); i++)
      check({name, "_step"}, seen[i], exp[i]);
  endtask

  initial begin
    int d0;
    int exp_q[$];

    // reset
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("rst_position", int'(position), 128);
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // upward move 128 -> 140 at speed 4
    d0 = done_cnt;
    send(140, 4);
    check("up_busy", int'(busy), 1);
    wait_done("up");
    exp_q = '{132, 136, 140};
    check_seen("up", exp_q);
    check("up_done_pulses", done_cnt - d0, 1);

    // downward with remainder 140 -> 131
    d0 = done_cnt;
    send(131, 4);
    wait_done("down");
    exp_q = '{136, 132, 131};
    check_seen("down", exp_q);
    check("down_done_pulses", done_cnt - d0, 1);

    // jump to 0
    d0 = done_cnt;
    send(0, 0);
    check("jump_position", int'(position), 0);
    check("jump_busy", int'(busy), 1);
    wait_done("jump");
    check("jump_done_pulses", done_cnt - d0, 1);

    // no-op to current position
    d0 = done_cnt;
    send(0, 9);
    check("noop_busy", int'(busy), 1);
    wait_done("noop");
    exp_q = {};
    check_seen("noop", exp_q);
    check("noop_done_pulses", done_cnt - d0, 1);

    // top boundary 250 -> 255, with an ignored command during MOVE
    send(250, 0);
    wait_done("pre_top");
    d0 = done_cnt;
    send(255, 15);
    check("top_busy", int'(busy), 1);
    check("top_ready_low", int'(cmd_ready), 0);
    cmd_valid = 1'b1; cmd_pos = 8'd10; cmd_speed = 4'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done("top");
    exp_q = '{255};
    check_seen("top", exp_q);
    check("top_final", int'(position), 255);
    check("top_done_pulses", done_cnt - d0, 1);
    repeat (6) @(negedge clk);
    check("top_ignored_cmd", int'(position), 255);

    // reset mid-move at 136
    send(128, 0);
    wait_done("pre_rst");
    send(144, 8);
    begin
      int c;
      c = 0;
      while (position != 8'd136 && c < 20) begin
        @(negedge clk);
        c++;
      end
      check("midrst_reached_136", int'(position), 136);
    end
    check("midrst_busy_before", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_position", int'(position), 128);
    check("midrst_busy", int'(busy), 0);
    check("midrst_ready", int'(cmd_ready), 1);
    rst = 1'b0;
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_hold_home", int'(position), 128);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
